shader_frame_sequencer: RTL and testbench
=========================================

Name: shader_frame_sequencer

Overview:
- Sequences the per-pixel shader datapath for the 800x600@60 VGA output: pixel-enable generation, raster counters, coordinate issue to the shader, sync/blank alignment through the shader pipeline, and a per-frame animation timer.
- Holds a frame-synchronous configuration interface (scroll, timer speed) so that software-side updates never tear mid-frame.
- Sits between the system clock and the shader pipeline; drives the VGA pins directly.

Parameters:
- CLK_DIV, 3, system clocks per pixel.
- H_VISIBLE, 800, visible pixels per line.
- H_SYNC_START, 840, first hsync-low pixel.
- H_SYNC_LEN, 128, hsync-low width in pixels.
- H_TOTAL, 1056, pixels per line.
- V_VISIBLE, 600, visible lines.
- V_SYNC_START, 601, first vsync-low line.
- V_SYNC_LEN, 4, vsync-low lines.
- V_TOTAL, 628, lines per frame.
- PIPE_LAT, 2, shader latency in pixel enables (1..8).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accepted when high with cfg_valid
- cfg_scroll_x  in  12  horizontal scroll offset
- cfg_scroll_y  in  12  vertical scroll offset
- cfg_speed  in  8  timer increment per frame
- px_en  out  1  one-clock pixel strobe
- px_x  out  12  shader x coordinate (scrolled)
- px_y  out  12  shader y coordinate (scrolled)
- px_active  out  1  issued pixel is visible
- frame_time  out  16  animation timer
- frame_start  out  1  one-clock pulse at pixel (0,0)
- sh_red  in  3  shader red, valid PIPE_LAT px_en after issue
- sh_green  in  3  shader green
- sh_blue  in  2  shader blue
- red_F  out  3  VGA red
- green_F  out  3  VGA green
- blue_F  out  2  VGA blue
- hsync  out  1  active-low
- vsync  out  1  active-low

Behaviour:
- Reset:
  - Divider, hcount, vcount, px_x, px_y, px_active, px_en, frame_start and colour outputs reset to 0.
  - hsync and vsync reset to 1; cfg_ready resets to 1; frame_time resets to 0.
  - Active scroll resets to 0, active speed to 1.
  - Delay-line stages reset to inactive, sync high.
  - Reset mid-frame restarts the raster at (0,0) on the first px_en after deassertion.
- Divider:
  - Counts 0..CLK_DIV-1; px_en is high exactly in the cycle the divider equals CLK_DIV-1.
  - Line period is H_TOTAL*CLK_DIV clocks.
- Raster:
  - On px_en, hcount increments, wrapping at H_TOTAL-1 to 0.
  - On that wrap, vcount increments, wrapping at V_TOTAL-1 to 0.
- Issue stage, registered on px_en:
  - px_x = (hcount + scroll_x) mod 4096; px_y = (vcount + scroll_y) mod 4096.
  - px_active = (hcount < H_VISIBLE) && (vcount < V_VISIBLE). Raw counters decide active, not the scrolled values.
- Alignment:
  - Raw hsync and vsync are computed from hcount/vcount:
    - low for H_SYNC_START <= hcount < H_SYNC_START+H_SYNC_LEN;
    - low for V_SYNC_START <= vcount < V_SYNC_START+V_SYNC_LEN.
  - hsync, vsync and active pass through a PIPE_LAT-deep shift register advanced only on px_en.
  - On px_en, colour outputs take sh_* when the delayed active bit is 1, else 0. Sync outputs update on the same px_en.
  - Total pin latency is PIPE_LAT+1 pixels from the counter value.
- frame_start is high for the single px_en cycle in which hcount=0 and vcount=0.
- Frame boundary (fb) is the px_en cycle in which hcount=H_TOTAL-1 and vcount=V_TOTAL-1.
- Config FSM, states IDLE and PENDING:
  - IDLE, cfg_ready=1: when cfg_valid is high, capture all cfg_* into shadow registers and go to PENDING. cfg_ready drops the next cycle.
  - PENDING, cfg_ready=0: at fb, copy shadow to active and return to IDLE. cfg_ready rises the cycle after fb.
  - If cfg_valid and fb coincide in IDLE, the capture goes to PENDING and applies at the following fb, never the same one.
- Timer:
  - At fb, frame_time += active speed, using the speed value in effect before any same-cycle shadow copy.
  - 16-bit wrap, no saturation.
  - Speed 0 freezes the timer.
- cfg_* are ignored when cfg_ready=0; no queueing.

Decomposition:
- Shared package holds the VGA 800x600 timing constants, colour widths (3/3/2), the 12-bit coordinate width, and the config FSM state encoding.
- One natural sub-module: sync_delay_line (parameterised depth, px_en-gated shift of {hsync, vsync, active}).

Test Plan:
- Reset, then 2*H_TOTAL*CLK_DIV clocks -> px_en period of 3 clocks; hcount wraps after 1055; hsync low for exactly 128 px_en starting PIPE_LAT+1 pixels after hcount=840.
- Run one full frame -> vsync low for 4 lines (4224 px_en) starting on line 601; frame_start pulses once per 1056*628 px_en.
- With sh_* = 3'b111/3'b111/2'b11 constant -> colours nonzero only in the 800x600 window shifted PIPE_LAT+1 pixels; zero in blanking.
- cfg_valid with scroll_x=100 mid-frame -> cfg_ready low until the cycle after fb; px_x at hcount=0 is 100 in the next frame only. A second cfg_valid while pending is ignored.
- cfg_speed=0xFF, run 257 frames -> frame_time = (1 + 256*255) mod 65536 = 0xFF01, counting one frame at the reset speed of 1 before the first apply.
- Assert reset at line 300 for 5 clocks -> all outputs at reset values during reset; after release, the first px_en issues (0,0) and frame_start pulses.

Source files
------------

// File: rtl/shader_frame_sequencer_pkg.sv
// shader_frame_sequencer_pkg: shared VGA timing, widths and config FSM encoding
package shader_frame_sequencer_pkg;
  localparam int COORD_W = 12;
  localparam int RED_W = 3;
  localparam int GREEN_W = 3;
  localparam int BLUE_W = 2;
  localparam int SPEED_W = 8;
  localparam int TIME_W = 16;
  localparam int VGA_CLK_DIV = 3;
  localparam int VGA_H_VISIBLE = 800;
  localparam int VGA_H_SYNC_START = 840;
  localparam int VGA_H_SYNC_LEN = 128;
  localparam int VGA_H_TOTAL = 1056;
  localparam int VGA_V_VISIBLE = 600;
  localparam int VGA_V_SYNC_START = 601;
  localparam int VGA_V_SYNC_LEN = 4;
  localparam int VGA_V_TOTAL = 628;
  localparam int VGA_PIPE_LAT = 2;
  typedef enum logic {CFG_IDLE = 1'b0, CFG_PENDING = 1'b1} cfg_state_e;
  typedef struct packed {
    logic [COORD_W-1:0] scroll_x;
    logic [COORD_W-1:0] scroll_y;
    logic [SPEED_W-1:0] speed;
  } cfg_t;
  function automatic logic in_window(logic [COORD_W-1:0] c, int start, int len);
    return (int'(c) >= start) && (int'(c) < start + len);
  endfunction
endpackage

// File: rtl/shader_frame_sequencer_sync_delay_line.sv
// sync_delay_line: pixel-gated shift of {hsync, vsync, active} matching shader latency
module sync_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic hs_i,
  input  logic vs_i,
  input  logic act_i,
  output logic hs_o,
  output logic vs_o,
  output logic act_o
);
  logic [2:0] sr_q [DEPTH];
  // advance one stage per pixel; idle stages look like blanking with syncs released
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= 3'b110;
    end else if (en_i) begin
      sr_q[0] <= {hs_i, vs_i, act_i};
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  assign {hs_o, vs_o, act_o} = sr_q[DEPTH-1];
endmodule

// File: rtl/shader_frame_sequencer.sv
// shader_frame_sequencer: VGA raster, shader coordinate issue, sync alignment and frame-synchronous config
module shader_frame_sequencer
  import shader_frame_sequencer_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_SYNC_START = VGA_H_SYNC_START,
  parameter int H_SYNC_LEN = VGA_H_SYNC_LEN,
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_SYNC_START = VGA_V_SYNC_START,
  parameter int V_SYNC_LEN = VGA_V_SYNC_LEN,
  parameter int V_TOTAL = VGA_V_TOTAL,
  parameter int PIPE_LAT = VGA_PIPE_LAT
) (
  input  logic clock,
  input  logic reset,
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic [COORD_W-1:0] cfg_scroll_x,
  input  logic [COORD_W-1:0] cfg_scroll_y,
  input  logic [SPEED_W-1:0] cfg_speed,
  output logic px_en,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic px_active,
  output logic [TIME_W-1:0] frame_time,
  output logic frame_start,
  input  logic [RED_W-1:0] sh_red,
  input  logic [GREEN_W-1:0] sh_green,
  input  logic [BLUE_W-1:0] sh_blue,
  output logic [RED_W-1:0] red_F,
  output logic [GREEN_W-1:0] green_F,
  output logic [BLUE_W-1:0] blue_F,
  output logic hsync,
  output logic vsync
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  logic [DIV_W-1:0] div_q, div_d;
  logic [COORD_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic [COORD_W-1:0] px_x_q, px_y_q;
  logic px_active_q;
  logic [RED_W-1:0] red_q;
  logic [GREEN_W-1:0] green_q;
  logic [BLUE_W-1:0] blue_q;
  logic hsync_q, vsync_q;
  logic h_wrap, v_wrap, fb;
  logic hs_raw, vs_raw, act_raw, dl_hs, dl_vs, dl_act;
  cfg_state_e state_q, state_d;
  cfg_t shadow_q, active_q;
  logic [TIME_W-1:0] time_q;
  logic cap, apply;
  assign px_en = div_q == DIV_W'(CLK_DIV - 1);
  assign h_wrap = hcount_q == COORD_W'(H_TOTAL - 1);
  assign v_wrap = vcount_q == COORD_W'(V_TOTAL - 1);
  assign fb = px_en && h_wrap && v_wrap;
  assign frame_start = px_en && hcount_q == '0 && vcount_q == '0;
  assign hs_raw = !in_window(hcount_q, H_SYNC_START, H_SYNC_LEN);
  assign vs_raw = !in_window(vcount_q, V_SYNC_START, V_SYNC_LEN);
  assign act_raw = in_window(hcount_q, 0, H_VISIBLE) && in_window(vcount_q, 0, V_VISIBLE);
  // divider and raster next state; vertical advances only on the horizontal wrap
  always_comb begin
    div_d = px_en ? '0 : div_q + DIV_W'(1);
    hcount_d = !px_en ? hcount_q : h_wrap ? '0 : hcount_q + COORD_W'(1);
    vcount_d = !(px_en && h_wrap) ? vcount_q : v_wrap ? '0 : vcount_q + COORD_W'(1);
  end
  // raster state registers
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      div_q <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      div_q <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  // issue scrolled coordinates; visibility comes from the raw raster, not the scrolled view
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      px_x_q <= '0;
      px_y_q <= '0;
      px_active_q <= 1'b0;
    end else if (px_en) begin
      px_x_q <= hcount_q + active_q.scroll_x;
      px_y_q <= vcount_q + active_q.scroll_y;
      px_active_q <= act_raw;
    end
  sync_delay_line #(.DEPTH(PIPE_LAT)) u_delay (
    .clk_i(clock),
    .rst_i(reset),
    .en_i(px_en),
    .hs_i(hs_raw),
    .vs_i(vs_raw),
    .act_i(act_raw),
    .hs_o(dl_hs),
    .vs_o(dl_vs),
    .act_o(dl_act)
  );
  // pin stage: shader colour is blanked outside the delayed visible window
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      {red_q, green_q, blue_q} <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (px_en) begin
      {red_q, green_q, blue_q} <= dl_act ? {sh_red, sh_green, sh_blue} : '0;
      hsync_q <= dl_hs;
      vsync_q <= dl_vs;
    end
  // config FSM: capture when idle, publish only at the frame boundary
  always_comb begin
    cap = state_q == CFG_IDLE && cfg_valid;
    apply = state_q == CFG_PENDING && fb;
    state_d = cap ? CFG_PENDING : apply ? CFG_IDLE : state_q;
  end
  // config and timer registers; the timer sees the speed held before a same-cycle publish
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= CFG_IDLE;
      shadow_q <= '0;
      active_q <= '{scroll_x: '0, scroll_y: '0, speed: SPEED_W'(1)};
      time_q <= '0;
    end else begin
      state_q <= state_d;
      if (cap) shadow_q <= '{scroll_x: cfg_scroll_x, scroll_y: cfg_scroll_y, speed: cfg_speed};
      if (apply) active_q <= shadow_q;
      if (fb) time_q <= time_q + TIME_W'(active_q.speed);
    end
  assign cfg_ready = state_q == CFG_IDLE;
  assign px_x = px_x_q;
  assign px_y = px_y_q;
  assign px_active = px_active_q;
  assign frame_time = time_q;
  assign red_F = red_q;
  assign green_F = green_q;
  assign blue_F = blue_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
endmodule

// File: tb/tb_shader_frame_sequencer.sv
// tb_shader_frame_sequencer: scoreboard bench on a reduced raster
module tb_shader_frame_sequencer;
  localparam int CD = 3, HV = 6, HSS = 7, HSL = 3, HT = 12;
  localparam int VV = 3, VSS = 4, VSL = 1, VT = 6, PL = 2;
  logic clock = 1'b0, reset = 1'b1, cfg_valid = 1'b0;
  logic [11:0] cfg_scroll_x = '0, cfg_scroll_y = '0;
  logic [7:0] cfg_speed = '0;
  logic [2:0] sh_red = 3'b111, sh_green = 3'b111;
  logic [1:0] sh_blue = 2'b11;
  logic cfg_ready, px_en, px_active, frame_start, hsync, vsync;
  logic [11:0] px_x, px_y;
  logic [15:0] frame_time;
  logic [2:0] red_F, green_F;
  logic [1:0] blue_F;
  typedef struct {logic hs; logic vs; logic [7:0] rgb;} pin_t;
  pin_t exp_q[$];
  pin_t pin_exp;
  int checks = 0, errors = 0;
  int mh, mv, cur_h, cur_v, gap;
  logic [11:0] m_sx, m_sy, p_sx, p_sy, n_x, n_y, e_x, e_y;
  logic [7:0] m_speed, p_speed;
  logic [15:0] m_time, cur_time;
  logic m_pend, m_ready, n_act, e_act, n_valid, e_valid, cur_fs, cur_fb, pin_valid;

  shader_frame_sequencer #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .V_TOTAL(VT), .PIPE_LAT(PL)
  ) dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_scroll_x(cfg_scroll_x), .cfg_scroll_y(cfg_scroll_y), .cfg_speed(cfg_speed),
    .px_en(px_en), .px_x(px_x), .px_y(px_y), .px_active(px_active),
    .frame_time(frame_time), .frame_start(frame_start),
    .sh_red(sh_red), .sh_green(sh_green), .sh_blue(sh_blue),
    .red_F(red_F), .green_F(green_F), .blue_F(blue_F), .hsync(hsync), .vsync(vsync)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    mh = 0; mv = 0; m_sx = '0; m_sy = '0; m_speed = 8'd1; m_time = '0;
    m_pend = 1'b0; m_ready = 1'b1; n_valid = 1'b0; exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // advance to the next px_en sample, push the pin expectation and step the reference model
  task automatic next_px();
    int n = 0;
    do begin @(negedge clock); n++; end while (!px_en && n < 8);
    gap = n;
    if (!px_en) begin
      checks++; errors++;
      $display("FAIL px_en_timeout: no px_en within %0d clocks", n);
    end
    cur_h = mh; cur_v = mv;
    cur_fs = mh == 0 && mv == 0;
    cur_fb = mh == HT-1 && mv == VT-1;
    cur_time = m_time;
    e_x = n_x; e_y = n_y; e_act = n_act; e_valid = n_valid;
    exp_q.push_back('{hs: !(mh >= HSS && mh < HSS+HSL), vs: !(mv >= VSS && mv < VSS+VSL),
                      rgb: (mh < HV && mv < VV) ? 8'hFF : 8'h00});
    pin_valid = exp_q.size() == PL + 2;
    if (pin_valid) pin_exp = exp_q.pop_front();
    n_x = 12'(mh + int'(m_sx));
    n_y = 12'(mv + int'(m_sy));
    n_act = mh < HV && mv < VV;
    n_valid = 1'b1;
    if (cur_fb) begin
      m_time = m_time + 16'(m_speed);
      if (m_pend) begin m_sx = p_sx; m_sy = p_sy; m_speed = p_speed; m_pend = 1'b0; m_ready = 1'b1; end
    end
    if (mh == HT-1) begin mh = 0; mv = (mv == VT-1) ? 0 : mv + 1; end
    else mh++;
  endtask

  task automatic send_cfg(input logic [11:0] sx, input logic [11:0] sy, input logic [7:0] sp);
    if (m_ready) begin p_sx = sx; p_sy = sy; p_speed = sp; m_pend = 1'b1; m_ready = 1'b0; end
    cfg_scroll_x = sx; cfg_scroll_y = sy; cfg_speed = sp; cfg_valid = 1'b1;
    @(posedge clock);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if ({px_en, frame_start, px_active} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {px_en, frame_start, px_active}); end
    checks++; if ({px_x, px_y} !== 24'd0) begin errors++; $display("FAIL reset_coords: got %h want 0", {px_x, px_y}); end
    checks++; if ({red_F, green_F, blue_F} !== 8'h00) begin errors++; $display("FAIL reset_colour: got %h want 00", {red_F, green_F, blue_F}); end
    checks++; if ({hsync, vsync, cfg_ready} !== 3'b111) begin errors++; $display("FAIL reset_sync_ready: got %b want 111", {hsync, vsync, cfg_ready}); end
    checks++; if (frame_time !== 16'h0000) begin errors++; $display("FAIL reset_frame_time: got %h want 0000", frame_time); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_raster();
    int lows = 0, first_low = -1;
    next_px();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL raster_first_frame_start: got %b want 1", frame_start); end
    for (int j = 1; j < 2*HT+PL+1; j++) begin
      next_px();
      checks++; if (gap != CD) begin errors++; $display("FAIL px_en_period: got %0d want %0d", gap, CD); end
      checks++; if ({px_x, px_y, px_active} !== {e_x, e_y, e_act}) begin errors++; $display("FAIL raster_issue h=%0d v=%0d: got %h/%h/%b want %h/%h/%b", cur_h, cur_v, px_x, px_y, px_active, e_x, e_y, e_act); end
      checks++; if (frame_start !== cur_fs) begin errors++; $display("FAIL raster_frame_start: got %b want %b", frame_start, cur_fs); end
      if (pin_valid) begin
        checks++; if ({hsync, vsync, red_F, green_F, blue_F} !== {pin_exp.hs, pin_exp.vs, pin_exp.rgb}) begin errors++; $display("FAIL raster_pins slot %0d: got %b%b/%h want %b%b/%h", j, hsync, vsync, {red_F, green_F, blue_F}, pin_exp.hs, pin_exp.vs, pin_exp.rgb); end
        if (!hsync) begin lows++; if (first_low < 0) first_low = j; end
      end
    end
    checks++; if (lows != 2*HSL) begin errors++; $display("FAIL hsync_width: got %0d want %0d", lows, 2*HSL); end
    checks++; if (first_low != HSS+PL+1) begin errors++; $display("FAIL hsync_latency: got slot %0d want %0d", first_low, HSS+PL+1); end
  endtask

  task automatic test_frame();
    int vlows = 0, starts = 0;
    for (int j = 0; j < HT*VT; j++) begin
      next_px();
      if (frame_start) starts++;
      checks++; if ({px_x, px_y, px_active} !== {e_x, e_y, e_act}) begin errors++; $display("FAIL frame_issue h=%0d v=%0d: got %h/%h/%b want %h/%h/%b", cur_h, cur_v, px_x, px_y, px_active, e_x, e_y, e_act); end
      if (pin_valid) begin
        checks++; if ({hsync, vsync, red_F, green_F, blue_F} !== {pin_exp.hs, pin_exp.vs, pin_exp.rgb}) begin errors++; $display("FAIL frame_pins h=%0d v=%0d: got %b%b/%h want %b%b/%h", cur_h, cur_v, hsync, vsync, {red_F, green_F, blue_F}, pin_exp.hs, pin_exp.vs, pin_exp.rgb); end
        if (!vsync) vlows++;
      end
    end
    checks++; if (vlows != VSL*HT) begin errors++; $display("FAIL vsync_width: got %0d want %0d", vlows, VSL*HT); end
    checks++; if (starts != 1) begin errors++; $display("FAIL frame_start_count: got %0d want 1", starts); end
  endtask

  task automatic test_config();
    do next_px(); while (!(cur_h == 2 && cur_v == 1));
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_idle: got %b want 1", cfg_ready); end
    send_cfg(12'd5, 12'd3, 8'd2);
    @(negedge clock);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_drop: got %b want 0", cfg_ready); end
    send_cfg(12'd9, 12'd9, 8'd9);
    do begin
      next_px();
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_pending h=%0d v=%0d: got %b want 0", cur_h, cur_v, cfg_ready); end
      checks++; if ({px_x, px_y} !== {e_x, e_y}) begin errors++; $display("FAIL cfg_old_scroll h=%0d v=%0d: got %h/%h want %h/%h", cur_h, cur_v, px_x, px_y, e_x, e_y); end
    end while (!cur_fb);
    @(negedge clock);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_rise: got %b want 1", cfg_ready); end
    next_px();
    checks++; if (px_x !== 12'd11) begin errors++; $display("FAIL cfg_last_unscrolled: got %0d want 11", px_x); end
    next_px();
    checks++; if ({px_x, px_y} !== {12'd5, 12'd3}) begin errors++; $display("FAIL cfg_scroll_applied: got %0d/%0d want 5/3", px_x, px_y); end
  endtask

  task automatic test_reset_mid();
    do next_px(); while (!(cur_h == 4 && cur_v == 2));
    #2 reset = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    checks++; if ({px_en, frame_start, px_active, px_x, px_y, red_F, green_F, blue_F, hsync, vsync, cfg_ready, frame_time} !== {3'b000, 24'd0, 8'd0, 3'b111, 16'd0})
      begin errors++; $display("FAIL reset_mid_outputs: got %b%b%b %h %h %h %b%b%b %h", px_en, frame_start, px_active, px_x, px_y, {red_F, green_F, blue_F}, hsync, vsync, cfg_ready, frame_time); end
    reset = 1'b0;
    model_reset();
    next_px();
    checks++; if (gap != CD-1) begin errors++; $display("FAIL reset_mid_first_px_en: got %0d clocks want %0d", gap, CD-1); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL reset_mid_frame_start: got %b want 1", frame_start); end
    next_px();
    checks++; if ({px_x, px_y, px_active} !== {24'd0, 1'b1}) begin errors++; $display("FAIL reset_mid_issue: got %0d/%0d/%b want 0/0/1", px_x, px_y, px_active); end
  endtask

  task automatic test_timer();
    int fbs = 0;
    do_reset();
    next_px();
    send_cfg(12'd0, 12'd0, 8'hFF);
    while (fbs < 257) begin
      next_px();
      if (cur_fb) begin
        fbs++;
        checks++; if (frame_time !== cur_time) begin errors++; $display("FAIL timer_step fb %0d: got %h want %h", fbs, frame_time, cur_time); end
      end
    end
    next_px();
    checks++; if (frame_time !== 16'hFF01) begin errors++; $display("FAIL timer_257_frames: got %h want ff01", frame_time); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL timer_ready: got %b want 1", cfg_ready); end
    send_cfg(12'd0, 12'd0, 8'h00);
    fbs = 0;
    while (fbs < 3) begin next_px(); if (cur_fb) fbs++; end
    next_px();
    checks++; if (frame_time !== 16'h0000) begin errors++; $display("FAIL timer_wrap_freeze: got %h want 0000", frame_time); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_raster();
    test_frame();
    test_config();
    test_reset_mid();
    test_timer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
